// File: rtl/ram32x4_rr_arbiter.sv
// Round-robin arbiter sharing one single-port 32x4 synchronous RAM between two req/gnt ports.
// Optional power-up clear of the RAM is compiled in with RAM32X4_ARB_CLEAR_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a request; arbitrates and latches the command
// S_ISSUE | command on the RAM bus, gnt pulse to the winner
// S_RWAIT | RAM read data settling; captured into rdata at cycle end
// S_CLEAR | (optional) zeroing every RAM word after reset, one per cycle
module ram32x4_rr_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 4
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              req0_i,
   input  logic              we0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [DATA_W-1:0] wdata0_i,
   output logic              gnt0_o,
   output logic              rvalid0_o,
   output logic [DATA_W-1:0] rdata0_o,
   input  logic              req1_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic              gnt1_o,
   output logic              rvalid1_o,
   output logic [DATA_W-1:0] rdata1_o,
   output logic              ram_write_o,
   output logic [ADDR_W-1:0] ram_address_o,
   output logic [DATA_W-1:0] ram_data_in_o,
   input  logic [DATA_W-1:0] ram_data_out_i,
   output logic              busy_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RWAIT = 2'd2;
`ifdef RAM32X4_ARB_CLEAR_EN
   localparam logic [1:0] S_CLEAR = 2'd3;
`endif

   logic [1:0]        state_q, state_d;
   logic              last_q, last_d;
   logic              port_q, port_d;
   logic              we_q, we_d;
   logic              ram_write_q, ram_write_d;
   logic [ADDR_W-1:0] ram_address_q, ram_address_d;
   logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              win;
`ifdef RAM32X4_ARB_CLEAR_EN
   logic              clr_pend_q, clr_pend_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

   // on a tie the port that was not served last wins
   assign win = (req0_i && req1_i) ? ~last_q : req1_i;

   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      port_d        = port_q;
      we_d          = we_q;
      ram_write_d   = 1'b0;
      ram_address_d = ram_address_q;
      ram_data_in_d = ram_data_in_q;
      gnt0_d        = 1'b0;
      gnt1_d        = 1'b0;
      rvalid0_d     = 1'b0;
      rvalid1_d     = 1'b0;
      rdata0_d      = rdata0_q;
      rdata1_d      = rdata1_q;
`ifdef RAM32X4_ARB_CLEAR_EN
      clr_pend_d    = clr_pend_q;
      clr_cnt_d     = clr_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
`ifdef RAM32X4_ARB_CLEAR_EN
            if (clr_pend_q) begin
               state_d       = S_CLEAR;
               clr_pend_d    = 1'b0;
               clr_cnt_d     = '0;
               ram_write_d   = 1'b1;
               ram_address_d = '0;
               ram_data_in_d = '0;
            end else
`endif
            if (req0_i || req1_i) begin
               state_d       = S_ISSUE;
               last_d        = win;
               port_d        = win;
               we_d          = win ? we1_i : we0_i;
               ram_write_d   = win ? we1_i : we0_i;
               ram_address_d = win ? addr1_i : addr0_i;
               ram_data_in_d = win ? wdata1_i : wdata0_i;
               gnt0_d        = ~win;
               gnt1_d        = win;
            end
         end
         S_ISSUE: begin
            state_d = we_q ? S_IDLE : S_RWAIT;
         end
         S_RWAIT: begin
            state_d = S_IDLE;
            if (port_q) begin
               rdata1_d  = ram_data_out_i;
               rvalid1_d = 1'b1;
            end else begin
               rdata0_d  = ram_data_out_i;
               rvalid0_d = 1'b1;
            end
         end
`ifdef RAM32X4_ARB_CLEAR_EN
         S_CLEAR: begin
            if (clr_cnt_q == {ADDR_W{1'b1}}) begin
               state_d = S_IDLE;
            end else begin
               clr_cnt_d     = clr_cnt_q + 1'b1;
               ram_address_d = clr_cnt_q + 1'b1;
               ram_write_d   = 1'b1;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         last_q        <= 1'b1;
         port_q        <= 1'b0;
         we_q          <= 1'b0;
         ram_write_q   <= 1'b0;
         ram_address_q <= '0;
         ram_data_in_q <= '0;
         gnt0_q        <= 1'b0;
         gnt1_q        <= 1'b0;
         rvalid0_q     <= 1'b0;
         rvalid1_q     <= 1'b0;
         rdata0_q      <= '0;
         rdata1_q      <= '0;
`ifdef RAM32X4_ARB_CLEAR_EN
         clr_pend_q    <= 1'b1;
         clr_cnt_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         port_q        <= port_d;
         we_q          <= we_d;
         ram_write_q   <= ram_write_d;
         ram_address_q <= ram_address_d;
         ram_data_in_q <= ram_data_in_d;
         gnt0_q        <= gnt0_d;
         gnt1_q        <= gnt1_d;
         rvalid0_q     <= rvalid0_d;
         rvalid1_q     <= rvalid1_d;
         rdata0_q      <= rdata0_d;
         rdata1_q      <= rdata1_d;
`ifdef RAM32X4_ARB_CLEAR_EN
         clr_pend_q    <= clr_pend_d;
         clr_cnt_q     <= clr_cnt_d;
`endif
      end
   end

   assign gnt0_o        = gnt0_q;
   assign gnt1_o        = gnt1_q;
   assign rvalid0_o     = rvalid0_q;
   assign rvalid1_o     = rvalid1_q;
   assign rdata0_o      = rdata0_q;
   assign rdata1_o      = rdata1_q;
   assign ram_write_o   = ram_write_q;
   assign ram_address_o = ram_address_q;
   assign ram_data_in_o = ram_data_in_q;
   assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram32x4_rr_arbiter.sv
// Bench for ram32x4_rr_arbiter: vector table, hand corner sequences and randomized pairs
// checked against a transaction-level round-robin model; RAM32X4_ARB_CLEAR_EN adds the clear test.
module tb_ram32x4_rr_arbiter;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [4:0] addr0 = '0, addr1 = '0;
   logic [3:0] wdata0 = '0, wdata1 = '0;
   logic       gnt0, gnt1, rvalid0, rvalid1, ram_write, busy;
   logic [3:0] rdata0, rdata1, ram_data_in;
   logic [3:0] ram_data_out = '0;
   logic [4:0] ram_address;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [3:0] ram_mem [32];
   logic [3:0] ref_mem [32];
   bit         lg;
   logic [3:0] held0, held1;

   typedef struct {
      bit         port;
      bit         we;
      logic [4:0] addr;
      logic [3:0] wdata;
      logic [3:0] exp;
   } vec_t;
   vec_t vecs [8];

   ram32x4_rr_arbiter dut (
      .clock_i(clock), .reset_i(reset),
      .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
      .gnt0_o(gnt0), .rvalid0_o(rvalid0), .rdata0_o(rdata0),
      .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
      .gnt1_o(gnt1), .rvalid1_o(rvalid1), .rdata1_o(rdata1),
      .ram_write_o(ram_write), .ram_address_o(ram_address),
      .ram_data_in_o(ram_data_in), .ram_data_out_i(ram_data_out),
      .busy_o(busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // single-port RAM with registered read
   always @(posedge clock) begin
      if (ram_write) ram_mem[ram_address] <= ram_data_in;
      ram_data_out <= ram_mem[ram_address];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 0);
      chk("rvalid_exclusive", {31'd0, rvalid0 & rvalid1}, 0);
   end

   task automatic model_reset();
      lg = 1'b1;
      held0 = '0;
      held1 = '0;
`ifdef RAM32X4_ARB_CLEAR_EN
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
`endif
   endtask

   task automatic release_reset();
      reset = 1'b0;
      model_reset();
      @(posedge clock); #1;
      for (int k = 0; k < 40 && busy; k++) begin
         @(posedge clock); #1;
      end
      chk("reset_settle_busy", {31'd0, busy}, 0);
   endtask

   task automatic tb_reset();
      reset = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      @(posedge clock); @(posedge clock); #1;
      release_reset();
   endtask

   function automatic bit gnt_of(input bit p);
      return p ? gnt1 : gnt0;
   endfunction

   // one transaction on one port with latency and bus checks
   task automatic do_txn(input bit p, input bit we, input logic [4:0] a, input logic [3:0] d,
                         input logic [3:0] exp);
      int e, g;
      bit seen;
      e = cyc;
      seen = 1'b0;
      if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
      else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
      for (int k = 0; k < 10 && !seen; k++) begin
         @(posedge clock); #1;
         seen = gnt_of(p);
      end
      chk("txn_gnt_seen", {31'd0, seen}, 1);
      g = cyc;
      chk("txn_gnt_latency", g - e, 1);
      chk("txn_ram_write", {31'd0, ram_write}, {31'd0, we});
      chk("txn_ram_address", {27'd0, ram_address}, {27'd0, a});
      if (we) chk("txn_ram_data_in", {28'd0, ram_data_in}, {28'd0, d});
      req0 = 1'b0;
      req1 = 1'b0;
      lg = p;
      @(posedge clock); #1;
      chk("txn_ram_write_after", {31'd0, ram_write}, 0);
      if (we) begin
         ref_mem[a] = d;
      end else begin
         seen = p ? rvalid1 : rvalid0;
         for (int k = 0; k < 5 && !seen; k++) begin
            @(posedge clock); #1;
            seen = p ? rvalid1 : rvalid0;
         end
         chk("txn_rvalid_latency", cyc - g, 2);
         chk("txn_rdata", {28'd0, (p ? rdata1 : rdata0)}, {28'd0, exp});
         if (p) held1 = exp; else held0 = exp;
      end
   endtask

   // both/either port requesting in the same cycle; order and timing predicted from round-robin rule
   task automatic pair(input bit en0, input bit w0, input logic [4:0] a0, input logic [3:0] d0,
                       input bit en1, input bit w1, input logic [4:0] a1, input logic [3:0] d1);
      bit         ord [2];
      bit         wa [2];
      logic [4:0] aa [2];
      logic [3:0] da [2];
      logic [3:0] ex [2];
      int         gc [2];
      int         rc [2];
      int         n, e, t, endc;
      bit         p;
      wa[0] = w0; wa[1] = w1; aa[0] = a0; aa[1] = a1; da[0] = d0; da[1] = d1;
      gc[0] = -1; gc[1] = -1; rc[0] = -1; rc[1] = -1; ex[0] = '0; ex[1] = '0;
      e = cyc;
      if (en0 && en1) begin
         ord[0] = (lg == 1'b1) ? 1'b0 : 1'b1;
         ord[1] = ~ord[0];
         n = 2;
      end else begin
         ord[0] = en1;
         ord[1] = 1'b0;
         n = 1;
      end
      t = e + 1;
      endc = 0;
      for (int i = 0; i < n; i++) begin
         p = ord[i];
         gc[p] = t;
         if (wa[p]) begin
            ref_mem[aa[p]] = da[p];
            endc = t + 1;
            t = t + 2;
         end else begin
            ex[p] = ref_mem[aa[p]];
            rc[p] = t + 2;
            endc = t + 2;
            t = t + 3;
         end
         lg = p;
      end
      req0 = en0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = en1; we1 = w1; addr1 = a1; wdata1 = d1;
      while (cyc < endc) begin
         @(posedge clock); #1;
         chk("pair_gnt0", {31'd0, gnt0}, {31'd0, cyc == gc[0]});
         chk("pair_gnt1", {31'd0, gnt1}, {31'd0, cyc == gc[1]});
         chk("pair_rvalid0", {31'd0, rvalid0}, {31'd0, cyc == rc[0]});
         chk("pair_rvalid1", {31'd0, rvalid1}, {31'd0, cyc == rc[1]});
         if (cyc == rc[0]) held0 = ex[0];
         if (cyc == rc[1]) held1 = ex[1];
         chk("pair_rdata0", {28'd0, rdata0}, {28'd0, held0});
         chk("pair_rdata1", {28'd0, rdata1}, {28'd0, held1});
         if (gnt0) req0 = 1'b0;
         if (gnt1) req1 = 1'b0;
      end
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   initial begin
      int g, prev;
      bit seen;
      bit e0, e1;
      for (int i = 0; i < 32; i++) begin
         ram_mem[i] = '0;
         ref_mem[i] = '0;
      end
      vecs[0] = '{1'b0, 1'b1, 5'd5,  4'hA, 4'h0};
      vecs[1] = '{1'b0, 1'b0, 5'd5,  4'h0, 4'hA};
      vecs[2] = '{1'b0, 1'b0, 5'd1,  4'h0, 4'h1};
      vecs[3] = '{1'b1, 1'b0, 5'd2,  4'h0, 4'h2};
      vecs[4] = '{1'b1, 1'b1, 5'd31, 4'h3, 4'h0};
      vecs[5] = '{1'b0, 1'b0, 5'd31, 4'h0, 4'h3};
      vecs[6] = '{1'b1, 1'b1, 5'd0,  4'hF, 4'h0};
      vecs[7] = '{1'b1, 1'b0, 5'd0,  4'h0, 4'hF};

      // reset values while reset is held
      @(posedge clock); #1;
      chk("rst_gnt", {30'd0, gnt0, gnt1}, 0);
      chk("rst_rvalid", {30'd0, rvalid0, rvalid1}, 0);
      chk("rst_ram_write", {31'd0, ram_write}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_ram_address", {27'd0, ram_address}, 0);
      chk("rst_ram_data_in", {28'd0, ram_data_in}, 0);
      chk("rst_rdata", {24'd0, rdata0, rdata1}, 0);
      release_reset();

      // simultaneous writes first after reset: port 0 wins the tie
      pair(1'b1, 1'b1, 5'd1, 4'h1, 1'b1, 1'b1, 5'd2, 4'h2);

      for (int i = 0; i < 8; i++)
         do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

      // continuous reads from both ports: 6 alternating transactions
      for (int i = 0; i < 3; i++)
         pair(1'b1, 1'b0, 5'd1, 4'h0, 1'b1, 1'b0, 5'd2, 4'h0);

      // port 1 back-to-back writes 0..31 with req held high
      req1 = 1'b1; we1 = 1'b1; addr1 = 5'd0; wdata1 = 4'h0;
      prev = cyc;
      for (int i = 0; i < 32; i++) begin
         seen = 1'b0;
         for (int k = 0; k < 6 && !seen; k++) begin
            @(posedge clock); #1;
            seen = gnt1;
         end
         chk("b2b_spacing", cyc - prev, (i == 0) ? 1 : 2);
         chk("b2b_address", {27'd0, ram_address}, i);
         prev = cyc;
         ref_mem[i] = 4'(i);
         addr1 = 5'(i + 1);
         wdata1 = 4'(i + 1);
      end
      req1 = 1'b0;
      lg = 1'b1;
      @(posedge clock); #1;
      do_txn(1'b1, 1'b0, 5'd31, 4'h0, 4'hF);

      // reset during RWAIT discards the read
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd5;
      seen = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
         @(posedge clock); #1;
         seen = gnt0;
      end
      chk("rwait_gnt_seen", {31'd0, seen}, 1);
      req0 = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      chk("rwait_reset_busy", {31'd0, busy}, 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clock); #1;
         chk("rwait_reset_no_rvalid", {31'd0, rvalid0}, 0);
      end
      release_reset();
      do_txn(1'b0, 1'b0, 5'd5, 4'h0, ref_mem[5]);

      // randomized pairs against the round-robin model
      for (int i = 0; i < 40; i++) begin
         e0 = 1'($urandom_range(0, 1));
         e1 = e0 ? 1'($urandom_range(0, 1)) : 1'b1;
         pair(e0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 4'($urandom),
              e1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 4'($urandom));
      end

`ifdef RAM32X4_ARB_CLEAR_EN
      do_txn(1'b0, 1'b1, 5'd7, 4'h9, 4'h0);
      reset = 1'b1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd7;
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;
      model_reset();
      @(posedge clock); #1;
      g = 0;
      while (busy && !gnt0 && g < 60) begin
         chk("clear_ram_write", {31'd0, ram_write}, 1);
         chk("clear_address", {27'd0, ram_address}, g);
         g++;
         @(posedge clock); #1;
      end
      chk("clear_busy_cycles", g, 32);
      seen = gnt0;
      for (int k = 0; k < 4 && !seen; k++) begin
         @(posedge clock); #1;
         seen = gnt0;
      end
      chk("clear_gnt_after", {31'd0, seen}, 1);
      req0 = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
         @(posedge clock); #1;
         seen = rvalid0;
      end
      chk("clear_rvalid", {31'd0, seen}, 1);
      chk("clear_rdata", {28'd0, rdata0}, 0);
`endif

      @(posedge clock); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ram32x4_rr_arbiter.md
Name: ram32x4_rr_arbiter

Overview:
- Two-port round-robin controller that shares one single-port 32x4 synchronous RAM between two requesters (e.g. switch-driven user port and an autonomous test/scan engine).
- Sits between the requesters and the RAM instance. Drives the RAM's write/address/data_in and captures its data_out.
- Each requester uses a req/gnt handshake and gets read data back with a one-cycle valid strobe.

Parameters:
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32 words.
- DATA_W, 4, word width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; held high until gnt0 is seen.
- we0  in  1  port 0 op: 1 = write, 0 = read; stable while req0 is high.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  one-cycle pulse; port 0 command is on the RAM bus this cycle.
- rvalid0  out  1  one-cycle pulse; rdata0 is valid.
- rdata0  out  DATA_W  port 0 read data; held until the next port 0 read.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- ram_write  out  1  RAM write enable.
- ram_address  out  ADDR_W  RAM address.
- ram_data_in  out  DATA_W  RAM write data.
- ram_data_out  in  DATA_W  RAM registered read data, valid one cycle after the address is presented.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state = IDLE; gnt*, rvalid*, ram_write and busy = 0; ram_address, ram_data_in, rdata* = 0; last_grant = 1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, RWAIT (plus CLEAR when the optional feature is compiled in).
- IDLE:
  - If any req is high, latch winner, we, addr and wdata into command registers; next state = ISSUE.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only one req high: that port wins.
  - Both high: the port != last_grant wins.
  - last_grant updates to the winner on the IDLE->ISSUE transition.
- ISSUE (exactly 1 cycle):
  - ram_address and ram_data_in come from the command registers; ram_write = latched we.
  - gnt[winner] = 1.
  - Write: next state = IDLE. Read: next state = RWAIT.
- RWAIT (exactly 1 cycle):
  - ram_write = 0.
  - ram_data_out is captured into rdata[winner]; rvalid[winner] = 1 in the following cycle, which is the IDLE cycle.
  - next state = IDLE.
- Outside ISSUE, ram_write is 0. ram_address holds its last value.
- Latency, with req first sampled at edge N:
  - gnt high in cycle N+1.
  - Read: rvalid high in cycle N+3.
  - Maximum throughput: one write every 2 cycles, one read every 3 cycles.
- Requester rule: deassert req at the edge that ends the gnt cycle. A req still high in IDLE after its gnt is treated as a new request.
- Non-winning port: its req stays pending and is served in the next arbitration. There is no starvation, because the round-robin guarantees service within 2 transactions.
- rvalid0 and rvalid1 are never high in the same cycle. gnt0 and gnt1 are never high in the same cycle.
- Addresses are used as-is. Address 31 is a normal address; there is no wrap logic inside this block.
- Reset mid-operation (any state):
  - Immediate return to IDLE.
  - A pending read is discarded with no rvalid.
  - An in-flight write may or may not have landed in the RAM. The RAM's own reset governs its contents.

Optional Feature:
- Macro: RAM32X4_ARB_CLEAR_EN.
- Defined:
  - After reset deasserts, the FSM enters CLEAR instead of IDLE.
  - CLEAR writes 0 to addresses 0..31, one per cycle (ram_write = 1, ram_address = counter), taking 32 cycles.
  - busy = 1 and no gnt is issued during CLEAR; requests stay pending.
  - After address 31, next state = IDLE.
- Not defined: the CLEAR state and its counter are absent; the FSM leaves reset directly into IDLE.

Test Plan:
- Port 0 write: addr 5, data 4'hA; then port 0 read addr 5 -> gnt0 at N+1; ram_write = 1 only in the write ISSUE cycle; rvalid0 at N+3 with rdata0 = 4'hA.
- Both ports write in the same cycle, first after reset (p0: addr 1 = 4'h1, p1: addr 2 = 4'h2), both held -> gnt0 first, then gnt1; subsequent reads return 4'h1 and 4'h2 respectively.
- Both ports issue continuous reads for 6 transactions -> grants alternate 0,1,0,1,0,1; rvalid never overlaps between ports; rdata1 remains unchanged while port 0 is being served.
- Port 1 only, 32 back-to-back writes with addr 0..31 and data = addr[3:0], then read back addr 31 -> rdata1 = 4'hF; writes at 2-cycle spacing.
- Port 0 read: assert reset during RWAIT -> no rvalid0; busy = 0; after release, a fresh read completes normally.
- With RAM32X4_ARB_CLEAR_EN: preload addr 7 = 4'h9, pulse reset, hold req0 read addr 7 -> busy high for 32 cycles with no gnt0; then rdata0 = 4'h0.
